// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared router packet type and header field layout helpers
package router_pkg;

    localparam int PACKET_TYPE_WIDTH = 4;
    localparam logic [PACKET_TYPE_WIDTH-1:0] ROUTING_HEADER = 4'hA;

    // Header layout, LSB first: dest_y, dest_x, src_y, src_x, len; type sits at the top.
    function automatic int hdr_dst_y_lsb(input int xw, input int yw);
        return 0;
    endfunction

    function automatic int hdr_dst_x_lsb(input int xw, input int yw);
        return yw;
    endfunction

    function automatic int hdr_src_y_lsb(input int xw, input int yw);
        return xw + yw;
    endfunction

    function automatic int hdr_src_x_lsb(input int xw, input int yw);
        return xw + 2 * yw;
    endfunction

    function automatic int hdr_len_lsb(input int xw, input int yw);
        return 2 * (xw + yw);
    endfunction

endpackage

// File: rtl/axis_if.sv
// rtl/axis_if.sv - AXI-Stream style interface with master and slave modports
interface axis_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;

    modport m (output tdata, output tvalid, output tlast, input tready);
    modport s (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_reg_slice.sv
// rtl/axis_reg_slice.sv - two-entry skid buffer with fully registered outputs
module axis_reg_slice #(
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] s_tdata,
    input  logic             s_tvalid,
    output logic             s_tready,
    output logic [WIDTH-1:0] m_tdata,
    output logic             m_tvalid,
    input  logic             m_tready
);

    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;

    // Upstream ready depends only on skid occupancy, so it never waits on m_tready.
    assign s_tready = !skid_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_tvalid   <= 1'b0;
            m_tdata    <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (m_tready || !m_tvalid) begin
            if (skid_valid) begin
                m_tvalid   <= 1'b1;
                m_tdata    <= skid_data;
                skid_valid <= 1'b0;
            end else begin
                m_tvalid <= s_tvalid;
                if (s_tvalid) begin
                    m_tdata <= s_tdata;
                end
            end
        end else if (s_tvalid && !skid_valid) begin
            skid_valid <= 1'b1;
            skid_data  <= s_tdata;
        end
    end

endmodule

// File: rtl/axis_packetizer.sv
// rtl/axis_packetizer.sv - prepends a routing header to a counted payload stream
module axis_packetizer
    import router_pkg::*;
#(
    parameter int DATA_WIDTH          = 32,
    parameter int MAX_ROUTERS_X       = 4,
    parameter int MAX_ROUTERS_Y       = 4,
    parameter int MAX_ROUTERS_X_WIDTH = $clog2(MAX_ROUTERS_X),
    parameter int MAX_ROUTERS_Y_WIDTH = $clog2(MAX_ROUTERS_Y)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [MAX_ROUTERS_X_WIDTH-1:0] router_x,
    input  logic [MAX_ROUTERS_Y_WIDTH-1:0] router_y,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic [MAX_ROUTERS_X_WIDTH-1:0] cmd_dest_x,
    input  logic [MAX_ROUTERS_Y_WIDTH-1:0] cmd_dest_y,
    input  logic [7:0]                     cmd_len,
    axis_if.s                              in,
    axis_if.m                              out,
    output logic                           err_len,
    output logic                           err_hdr
);

    localparam int XW       = MAX_ROUTERS_X_WIDTH;
    localparam int YW       = MAX_ROUTERS_Y_WIDTH;
    localparam int LEN_LSB  = hdr_len_lsb(XW, YW);
    localparam int SRCX_LSB = hdr_src_x_lsb(XW, YW);
    localparam int SRCY_LSB = hdr_src_y_lsb(XW, YW);
    localparam int DSTX_LSB = hdr_dst_x_lsb(XW, YW);
    localparam int DSTY_LSB = hdr_dst_y_lsb(XW, YW);

    if (XW != YW || 2 * (XW + YW) + 8 + PACKET_TYPE_WIDTH > DATA_WIDTH) begin : g_param_check
        $error("axis_packetizer: coordinate widths differ or header does not fit DATA_WIDTH");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HDR     = 2'd1,
        PAYLOAD = 2'd2
    } state_t;

    state_t          state;
    logic [7:0]      cnt;
    logic [7:0]      len_q;
    logic [XW-1:0]   dest_x_q;
    logic [YW-1:0]   dest_y_q;
    logic [XW-1:0]   src_x_q;
    logic [YW-1:0]   src_y_q;

    logic                  slice_ready;
    logic                  slice_valid;
    logic [DATA_WIDTH:0]   slice_in;
    logic [DATA_WIDTH:0]   slice_out;
    logic [DATA_WIDTH-1:0] hdr;
    logic                  in_hs;

    always_comb begin
        hdr = '0;
        hdr[DATA_WIDTH-1 -: PACKET_TYPE_WIDTH] = ROUTING_HEADER;
        hdr[LEN_LSB  +: 8]  = len_q;
        hdr[SRCX_LSB +: XW] = src_x_q;
        hdr[SRCY_LSB +: YW] = src_y_q;
        hdr[DSTX_LSB +: XW] = dest_x_q;
        hdr[DSTY_LSB +: YW] = dest_y_q;
    end

    assign cmd_ready   = (state == IDLE);
    assign in.tready   = (state == PAYLOAD) && slice_ready;
    assign in_hs       = in.tvalid && in.tready;
    assign slice_valid = (state == HDR) || ((state == PAYLOAD) && in.tvalid);
    assign slice_in    = (state == HDR) ? {1'b0, hdr} : {(cnt == 8'd1), in.tdata};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= 8'd0;
            len_q    <= 8'd0;
            dest_x_q <= '0;
            dest_y_q <= '0;
            src_x_q  <= '0;
            src_y_q  <= '0;
            err_len  <= 1'b0;
            err_hdr  <= 1'b0;
        end else begin
            err_len <= 1'b0;
            err_hdr <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_len == 8'd0) begin
                            err_len <= 1'b1;
                        end else begin
                            len_q    <= cmd_len;
                            dest_x_q <= cmd_dest_x;
                            dest_y_q <= cmd_dest_y;
                            src_x_q  <= router_x;
                            src_y_q  <= router_y;
                            state    <= HDR;
                        end
                    end
                end
                HDR: begin
                    if (slice_ready) begin
                        cnt   <= len_q;
                        state <= PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (in_hs) begin
                        cnt     <= cnt - 8'd1;
                        err_hdr <= (in.tdata[DATA_WIDTH-1 -: PACKET_TYPE_WIDTH] == ROUTING_HEADER);
                        if (cnt == 8'd1) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    axis_reg_slice #(
        .WIDTH(DATA_WIDTH + 1)
    ) u_slice (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_tdata  (slice_in),
        .s_tvalid (slice_valid),
        .s_tready (slice_ready),
        .m_tdata  (slice_out),
        .m_tvalid (out.tvalid),
        .m_tready (out.tready)
    );

    assign out.tdata = slice_out[DATA_WIDTH-1:0];
    assign out.tlast = slice_out[DATA_WIDTH];

endmodule

// File: tb/tb_axis_packetizer.sv
// tb/tb_axis_packetizer.sv - directed self-checking bench for axis_packetizer
module tb_axis_packetizer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] router_x, router_y;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_dest_x, cmd_dest_y;
    logic [7:0] cmd_len;
    logic       err_len, err_hdr;

    axis_if #(.DATA_WIDTH(32)) in_if ();
    axis_if #(.DATA_WIDTH(32)) out_if ();

    axis_packetizer #(
        .DATA_WIDTH(32), .MAX_ROUTERS_X(4), .MAX_ROUTERS_Y(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .router_x(router_x), .router_y(router_y),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dest_x(cmd_dest_x),
        .cmd_dest_y(cmd_dest_y), .cmd_len(cmd_len), .in(in_if), .out(out_if),
        .err_len(err_len), .err_hdr(err_hdr)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          errl_cnt = 0;
    int          errh_cnt = 0;
    int          last_acc = 0;
    bit          rdy_mode = 1'b0;
    logic [31:0] in_q[$];
    logic [32:0] beats[$];
    int          bcyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Payload source: presents the queue head and pops on each handshake.
    initial begin
        logic hs;
        in_if.tvalid = 1'b0;
        in_if.tdata  = '0;
        in_if.tlast  = 1'b0;
        forever begin
            @(negedge clk);
            hs = in_if.tvalid && in_if.tready;
            @(posedge clk);
            #1;
            if (hs && in_q.size() > 0) void'(in_q.pop_front());
            in_if.tvalid = (in_q.size() > 0);
            in_if.tdata  = (in_q.size() > 0) ? in_q[0] : 32'd0;
        end
    end

    initial begin
        out_if.tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_if.tready = rdy_mode ? !out_if.tready : 1'b1;
        end
    end

    // Sink monitor: collects accepted beats and checks hold-while-stalled.
    initial begin
        logic        stalled;
        logic [32:0] held;
        stalled = 1'b0;
        held    = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    check("stall_valid", {63'd0, out_if.tvalid}, 64'd1);
                    check("stall_data", {31'd0, out_if.tlast, out_if.tdata}, {31'd0, held});
                end
                if (out_if.tvalid && out_if.tready) begin
                    beats.push_back({out_if.tlast, out_if.tdata});
                    bcyc.push_back(cyc);
                end
                stalled = out_if.tvalid && !out_if.tready;
                held    = {out_if.tlast, out_if.tdata};
                if (err_len) errl_cnt++;
                if (err_hdr) errh_cnt++;
            end
        end
    end

    // Call just after a posedge; returns just after the accepting posedge with
    // cmd_valid dropped, so two calls in a row present commands back to back.
    task automatic send_cmd(input logic [1:0] dx, input logic [1:0] dy, input logic [7:0] len);
        int i;
        cmd_valid  = 1'b1;
        cmd_dest_x = dx;
        cmd_dest_y = dy;
        cmd_len    = len;
        for (i = 0; i < 200; i++) begin
            @(negedge clk);
            if (cmd_ready) break;
        end
        check("cmd_accept_timeout", {63'd0, cmd_ready}, 64'd1);
        last_acc = cyc;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_beats(input string tag, input int n);
        for (int i = 0; i < 300 && beats.size() < n; i++) @(negedge clk);
        check(tag, 64'(beats.size()), 64'(n));
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int e0, acc1;
        rst_n      = 1'b0;
        router_x   = 2'd1;
        router_y   = 2'd2;
        cmd_valid  = 1'b0;
        cmd_dest_x = 2'd0;
        cmd_dest_y = 2'd0;
        cmd_len    = 8'd0;
        repeat (3) @(negedge clk);
        check("rst_tvalid", {63'd0, out_if.tvalid}, 64'd0);
        check("rst_tlast", {63'd0, out_if.tlast}, 64'd0);
        check("rst_tdata", {32'd0, out_if.tdata}, 64'd0);
        check("rst_err_len", {63'd0, err_len}, 64'd0);
        check("rst_err_hdr", {63'd0, err_hdr}, 64'd0);
        check("rst_in_tready", {63'd0, in_if.tready}, 64'd0);
        sync();
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_cmd_ready", {63'd0, cmd_ready}, 64'd1);

        // Basic packet; router coordinates change after accept and must not leak in.
        in_q.push_back(32'h1111_1111);
        in_q.push_back(32'h2222_2222);
        in_q.push_back(32'h3333_3333);
        sync();
        send_cmd(2'd3, 2'd0, 8'd3);
        router_x = 2'd0;
        router_y = 2'd0;
        wait_beats("p1_count", 4);
        check("p1_hdr", 64'(beats[0]), {31'd0, 1'b0, 32'hA000_036C});
        check("p1_a", 64'(beats[1]), {31'd0, 1'b0, 32'h1111_1111});
        check("p1_b", 64'(beats[2]), {31'd0, 1'b0, 32'h2222_2222});
        check("p1_c", 64'(beats[3]), {31'd0, 1'b1, 32'h3333_3333});
        check("p1_consec", 64'(bcyc[3] - bcyc[0]), 64'd3);
        check("p1_hdr_lat", 64'(bcyc[0] - last_acc), 64'd2);
        router_x = 2'd1;
        router_y = 2'd2;

        // Same packet under 1010 backpressure.
        beats.delete();
        bcyc.delete();
        rdy_mode = 1'b1;
        in_q.push_back(32'h1111_1111);
        in_q.push_back(32'h2222_2222);
        in_q.push_back(32'h3333_3333);
        sync();
        send_cmd(2'd3, 2'd0, 8'd3);
        wait_beats("p2_count", 4);
        check("p2_hdr", 64'(beats[0]), {31'd0, 1'b0, 32'hA000_036C});
        check("p2_a", 64'(beats[1]), {31'd0, 1'b0, 32'h1111_1111});
        check("p2_b", 64'(beats[2]), {31'd0, 1'b0, 32'h2222_2222});
        check("p2_c", 64'(beats[3]), {31'd0, 1'b1, 32'h3333_3333});
        rdy_mode = 1'b0;
        repeat (4) @(negedge clk);

        // Zero-length command.
        beats.delete();
        bcyc.delete();
        e0 = errl_cnt;
        sync();
        send_cmd(2'd2, 2'd2, 8'd0);
        repeat (6) @(negedge clk);
        check("len0_no_beats", 64'(beats.size()), 64'd0);
        check("len0_err_pulse", 64'(errl_cnt - e0), 64'd1);
        check("len0_cmd_ready", {63'd0, cmd_ready}, 64'd1);

        // Two len-1 commands back to back.
        in_q.push_back(32'h0000_AAAA);
        in_q.push_back(32'h0000_BBBB);
        sync();
        send_cmd(2'd0, 2'd1, 8'd1);
        acc1 = last_acc;
        send_cmd(2'd2, 2'd3, 8'd1);
        check("b2b_acc_gap", 64'(last_acc - acc1), 64'd3);
        wait_beats("b2b_count", 4);
        check("b2b_h1", 64'(beats[0]), {31'd0, 1'b0, 32'hA000_0161});
        check("b2b_p1", 64'(beats[1]), {31'd0, 1'b1, 32'h0000_AAAA});
        check("b2b_h2", 64'(beats[2]), {31'd0, 1'b0, 32'hA000_016B});
        check("b2b_p2", 64'(beats[3]), {31'd0, 1'b1, 32'h0000_BBBB});
        check("b2b_p1_cyc", 64'(bcyc[1] - bcyc[0]), 64'd1);
        check("b2b_h2_cyc", 64'(bcyc[2] - bcyc[0]), 64'd3);

        // Payload beat that looks like a routing header.
        beats.delete();
        bcyc.delete();
        e0 = errh_cnt;
        in_q.push_back(32'hA000_0005);
        in_q.push_back(32'h1234_5678);
        sync();
        send_cmd(2'd1, 2'd1, 8'd2);
        wait_beats("hdrcol_count", 3);
        check("hdrcol_hdr", 64'(beats[0]), {31'd0, 1'b0, 32'hA000_0265});
        check("hdrcol_fwd", 64'(beats[1]), {31'd0, 1'b0, 32'hA000_0005});
        check("hdrcol_last", 64'(beats[2]), {31'd0, 1'b1, 32'h1234_5678});
        repeat (2) @(negedge clk);
        check("hdrcol_err", 64'(errh_cnt - e0), 64'd1);

        // Reset in the middle of a 5-beat packet.
        beats.delete();
        bcyc.delete();
        for (int i = 0; i < 5; i++) in_q.push_back(32'hC000_0000 + 32'(i));
        sync();
        send_cmd(2'd3, 2'd3, 8'd5);
        wait_beats("mid_count", 3);
        sync();
        rst_n = 1'b0;
        #1;
        check("mid_rst_tvalid", {63'd0, out_if.tvalid}, 64'd0);
        check("mid_rst_in_tready", {63'd0, in_if.tready}, 64'd0);
        in_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        beats.delete();
        bcyc.delete();
        repeat (8) @(negedge clk);
        check("mid_no_partial", 64'(beats.size()), 64'd0);
        in_q.push_back(32'h0000_00EE);
        sync();
        send_cmd(2'd2, 2'd1, 8'd1);
        wait_beats("post_count", 2);
        check("post_hdr", 64'(beats[0]), {31'd0, 1'b0, 32'hA000_0169});
        check("post_beat", 64'(beats[1]), {31'd0, 1'b1, 32'h0000_00EE});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
